// File: rtl/ama_riscv_load_align_unit_if.sv
// Load-align bus: request from the MEM stage, word reads to memory, result back.
//   req_*   : load request handshake (valid/ready, byte address, funct3)
//   mem_*   : single-beat word read strobe/address and returned data
//   resp_*  : one-cycle result strobe with extended data and error flag
// slave is the load-align unit; master is everything around it (pipeline + memory).
interface ama_riscv_load_align_unit_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
);
  localparam int unsigned OFF_W = $clog2(XLEN/8);

  logic                req_valid;
  logic                req_ready;
  logic [AW-1:0]       req_addr;
  logic [2:0]          req_funct3;
  logic                mem_req;
  logic [AW-OFF_W-1:0] mem_addr;
  logic                mem_rvalid;
  logic [XLEN-1:0]     mem_rdata;
  logic                resp_valid;
  logic [XLEN-1:0]     resp_data;
  logic                resp_err;

  modport master (
    output req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/ama_riscv_load_align_unit.sv
// Load shift/mask/extend unit with two-beat fetch for word-crossing loads.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of ama_riscv_load_align_unit_if (request, memory, response)
// Fetches the naturally aligned word(s) covering the addressed bytes, then
// shifts, masks and sign/zero-extends them into an XLEN result.
module ama_riscv_load_align_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 32
) (
  input  logic clk,
  input  logic rst,
  ama_riscv_load_align_unit_if.slave bus
);
  localparam int unsigned OFF_W = $clog2(XLEN/8);
  localparam int unsigned WAW   = AW - OFF_W;
  localparam int unsigned CW    = OFF_W + 2;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

  state_t          state;
  logic            ready_q;
  logic            mem_req_q;
  logic [WAW-1:0]  mem_addr_q;
  logic            resp_valid_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;
  logic [OFF_W-1:0] off_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] beat0_q;

  logic            legal_c;
  logic            cross_c;
  logic [XLEN-1:0] fin_b0_c;
  logic [XLEN-1:0] fin_b1_c;
  logic [2*XLEN-1:0] cat_c;
  logic [XLEN-1:0] sel_c;
  logic [XLEN-1:0] mask_c;
  logic            sign_c;
  logic            res_sign_c;
  logic [XLEN-1:0] res_c;

  // Width legality of the incoming funct3 (ld/lwu only exist on 64-bit)
  always_comb begin
    legal_c = 1'b1;
    if (bus.req_funct3 == 3'b111) legal_c = 1'b0;
    if ((XLEN == 32) && ((bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110)))
      legal_c = 1'b0;
  end

  // Access spills into the next word when offset + size exceeds the word
  assign cross_c = (CW'({2'b00, off_q}) + CW'(4'd1 << f3_q[1:0])) > CW'(XLEN/8);

  // Result datapath: the final beat arrives on mem_rdata and is merged with beat0
  always_comb begin
    fin_b0_c = (state == WAIT1) ? beat0_q       : bus.mem_rdata;
    fin_b1_c = (state == WAIT1) ? bus.mem_rdata : '0;
    cat_c    = {fin_b1_c, fin_b0_c} >> {off_q, 3'b000};
    sel_c    = cat_c[XLEN-1:0];
    unique case (f3_q[1:0])
      2'd0: begin mask_c = XLEN'(8'hFF);        sign_c = sel_c[7];      end
      2'd1: begin mask_c = XLEN'(16'hFFFF);     sign_c = sel_c[15];     end
      2'd2: begin mask_c = XLEN'(32'hFFFF_FFFF); sign_c = sel_c[31];    end
      default: begin mask_c = '1;               sign_c = sel_c[XLEN-1]; end
    endcase
    // Full-width access: ~mask_c is zero so the data passes through untouched
    res_sign_c = sign_c && !f3_q[2];
    res_c      = (sel_c & mask_c) | (res_sign_c ? ~mask_c : '0);
  end

  // Fetch/response state machine with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      off_q        <= '0;
      f3_q         <= '0;
      beat0_q      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid && ready_q) begin
            ready_q <= 1'b0;
            off_q   <= bus.req_addr[OFF_W-1:0];
            f3_q    <= bus.req_funct3;
            if (legal_c) begin
              state      <= REQ0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= bus.req_addr[AW-1:OFF_W];
            end else begin
              // resp_data is deliberately left holding the previous result
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end
          end
        end
        REQ0: begin
          mem_req_q <= 1'b0;
          state     <= WAIT0;
        end
        WAIT0: begin
          if (bus.mem_rvalid) begin
            beat0_q <= bus.mem_rdata;
            if (cross_c) begin
              state      <= REQ1;
              mem_req_q  <= 1'b1;
              mem_addr_q <= mem_addr_q + WAW'(1);
            end else begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_data_q  <= res_c;
            end
          end
        end
        REQ1: begin
          mem_req_q <= 1'b0;
          state     <= WAIT1;
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_data_q  <= res_c;
          end
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_ama_riscv_load_align_unit.sv
// Directed bench for ama_riscv_load_align_unit: one 32-bit and one 64-bit
// instance, each with a small word memory answering mem_req after 'lat' cycles.
module tb_ama_riscv_load_align_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ama_riscv_load_align_unit_if #(.XLEN(32), .AW(32)) b32();
  ama_riscv_load_align_unit_if #(.XLEN(64), .AW(32)) b64();

  ama_riscv_load_align_unit #(.XLEN(32), .AW(32)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  ama_riscv_load_align_unit #(.XLEN(64), .AW(32)) dut64 (.clk(clk), .rst(rst), .bus(b64.slave));

  int n_cmp = 0;
  int n_bad = 0;
  int lat = 1;

  logic [31:0] mem32 [int unsigned];
  logic [63:0] mem64 [int unsigned];
  int unsigned q32[$];
  int unsigned q64[$];
  int rc32 = 0;
  int rc64 = 0;
  bit p32 = 1'b0;
  bit p64 = 1'b0;
  int c32 = 0;
  int c64 = 0;
  int unsigned a32 = 0;
  int unsigned a64 = 0;

  function automatic logic [31:0] rd32(input int unsigned a);
    return mem32.exists(a) ? mem32[a] : 32'h0;
  endfunction

  function automatic logic [63:0] rd64(input int unsigned a);
    return mem64.exists(a) ? mem64[a] : 64'h0;
  endfunction

  // 32-bit memory model and response monitor
  always @(posedge clk) begin
    b32.mem_rvalid <= 1'b0;
    if (b32.resp_valid) rc32 = rc32 + 1;
    if (p32) begin
      if (c32 == 0) begin
        b32.mem_rvalid <= 1'b1;
        b32.mem_rdata  <= rd32(a32);
        p32 = 1'b0;
      end else c32 = c32 - 1;
    end
    if (b32.mem_req) begin
      q32.push_back(32'(b32.mem_addr));
      if (lat <= 1) begin
        b32.mem_rvalid <= 1'b1;
        b32.mem_rdata  <= rd32(32'(b32.mem_addr));
      end else begin
        p32 = 1'b1;
        c32 = lat - 2;
        a32 = 32'(b32.mem_addr);
      end
    end
  end

  // 64-bit memory model and response monitor
  always @(posedge clk) begin
    b64.mem_rvalid <= 1'b0;
    if (b64.resp_valid) rc64 = rc64 + 1;
    if (p64) begin
      if (c64 == 0) begin
        b64.mem_rvalid <= 1'b1;
        b64.mem_rdata  <= rd64(a64);
        p64 = 1'b0;
      end else c64 = c64 - 1;
    end
    if (b64.mem_req) begin
      q64.push_back(32'(b64.mem_addr));
      if (lat <= 1) begin
        b64.mem_rvalid <= 1'b1;
        b64.mem_rdata  <= rd64(32'(b64.mem_addr));
      end else begin
        p64 = 1'b1;
        c64 = lat - 2;
        a64 = 32'(b64.mem_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one load and check response, latency, pulse width and memory traffic
  task automatic do_load(input bit w64, input string name, input logic [31:0] addr,
                         input logic [2:0] f3, input int nreq, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [63:0] data, input logic err,
                         input int lat_exp);
    int cyc;
    bit got;
    logic [63:0] obs_data;
    logic obs_err;
    @(negedge clk);
    q32.delete();
    q64.delete();
    if (w64) begin
      b64.req_valid = 1'b1; b64.req_addr = addr; b64.req_funct3 = f3;
      check({name, "_ready"}, 64'(b64.req_ready), 64'd1);
    end else begin
      b32.req_valid = 1'b1; b32.req_addr = addr; b32.req_funct3 = f3;
      check({name, "_ready"}, 64'(b32.req_ready), 64'd1);
    end
    @(negedge clk);
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
    cyc = 1;
    got = 1'b0;
    while (!got && cyc < 40) begin
      if (w64 ? b64.resp_valid : b32.resp_valid) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    obs_data = w64 ? b64.resp_data : 64'(b32.resp_data);
    obs_err  = w64 ? b64.resp_err  : b32.resp_err;
    check({name, "_timeout"}, 64'(got), 64'd1);
    check({name, "_latency"}, 64'(cyc), 64'(lat_exp));
    check({name, "_data"}, obs_data, data);
    check({name, "_err"}, 64'(obs_err), 64'(err));
    @(negedge clk);
    check({name, "_pulse"}, 64'(w64 ? b64.resp_valid : b32.resp_valid), 64'd0);
    check({name, "_ready_back"}, 64'(w64 ? b64.req_ready : b32.req_ready), 64'd1);
    if (w64) begin
      check({name, "_nreq"}, 64'(q64.size()), 64'(nreq));
      if (nreq > 0 && q64.size() > 0) check({name, "_addr0"}, 64'(q64[0]), 64'(a0));
      if (nreq > 1 && q64.size() > 1) check({name, "_addr1"}, 64'(q64[1]), 64'(a1));
    end else begin
      check({name, "_nreq"}, 64'(q32.size()), 64'(nreq));
      if (nreq > 0 && q32.size() > 0) check({name, "_addr0"}, 64'(q32[0]), 64'(a0));
      if (nreq > 1 && q32.size() > 1) check({name, "_addr1"}, 64'(q32[1]), 64'(a1));
    end
  endtask

  initial begin
    int rc_before;
    rst = 1'b1;
    b32.req_valid = 1'b0; b32.req_addr = '0; b32.req_funct3 = '0;
    b64.req_valid = 1'b0; b64.req_addr = '0; b64.req_funct3 = '0;
    @(negedge clk);
    check("rst_ready",      64'(b32.req_ready),  64'd1);
    check("rst_mem_req",    64'(b32.mem_req),    64'd0);
    check("rst_resp_valid", 64'(b32.resp_valid), 64'd0);
    check("rst_resp_err",   64'(b32.resp_err),   64'd0);
    check("rst_mem_addr",   64'(b32.mem_addr),   64'd0);
    check("rst_resp_data",  64'(b32.resp_data),  64'd0);
    check("rst_ready64",    64'(b64.req_ready),  64'd1);
    @(negedge clk);
    rst = 1'b0;

    // 32-bit aligned and crossing loads, L=1
    lat = 1;
    mem32[32'h400] = 32'h1234_8678;
    do_load(1'b0, "lb",  32'h1001, 3'b000, 1, 32'h400, 0, 64'h0000_0000_FFFF_FF86, 1'b0, 3);
    do_load(1'b0, "lbu", 32'h1001, 3'b100, 1, 32'h400, 0, 64'h0000_0000_0000_0086, 1'b0, 3);
    mem32[32'h400] = 32'hAABB_CCDD;
    mem32[32'h401] = 32'h1122_3344;
    do_load(1'b0, "lw_cross", 32'h1003, 3'b010, 2, 32'h400, 32'h401, 64'h0000_0000_2233_44AA, 1'b0, 5);
    mem32[32'h0] = 32'h8000_0000;
    mem32[32'h1] = 32'h0000_00FF;
    do_load(1'b0, "lh_cross",  32'h0003, 3'b001, 2, 32'h0, 32'h1, 64'h0000_0000_FFFF_FF80, 1'b0, 5);
    do_load(1'b0, "lhu_cross", 32'h0003, 3'b101, 2, 32'h0, 32'h1, 64'h0000_0000_0000_FF80, 1'b0, 5);
    do_load(1'b0, "ill_011", 32'h1000, 3'b011, 0, 0, 0, 64'h0000_0000_0000_FF80, 1'b1, 1);
    do_load(1'b0, "ill_111", 32'h1000, 3'b111, 0, 0, 0, 64'h0000_0000_0000_FF80, 1'b1, 1);
    do_load(1'b0, "lw_al", 32'h1000, 3'b010, 1, 32'h400, 0, 64'h0000_0000_AABB_CCDD, 1'b0, 3);

    // Reset in WAIT1 of a crossing lw (L=2); the late beat must be ignored
    lat = 2;
    mem32[32'h800] = 32'hDEAD_BEEF;
    q32.delete();
    @(negedge clk);
    b32.req_valid = 1'b1; b32.req_addr = 32'h1002; b32.req_funct3 = 3'b010;
    @(negedge clk);
    b32.req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_mid_nreq", 64'(q32.size()), 64'd2);
    rc_before = rc32;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_ready", 64'(b32.req_ready), 64'd1);
    check("rst_mid_data",  64'(b32.resp_data), 64'd0);
    repeat (6) @(negedge clk);
    check("rst_mid_no_resp", 64'(rc32), 64'(rc_before));
    do_load(1'b0, "lw_after_rst", 32'h2000, 3'b010, 1, 32'h800, 0, 64'h0000_0000_DEAD_BEEF, 1'b0, 4);

    // 64-bit: wrapping crossing ld, lwu/lw at offset 4, illegal width
    lat = 1;
    mem64[32'h1FFF_FFFF] = 64'h1111_1111_2222_2222;
    mem64[32'h0]         = 64'h3333_3333_4444_4444;
    do_load(1'b1, "ld_wrap", 32'hFFFF_FFFC, 3'b011, 2, 32'h1FFF_FFFF, 32'h0, 64'h4444_4444_1111_1111, 1'b0, 5);
    mem64[32'h20] = 64'h8000_0000_0000_0000;
    do_load(1'b1, "lwu64", 32'h104, 3'b110, 1, 32'h20, 0, 64'h0000_0000_8000_0000, 1'b0, 3);
    do_load(1'b1, "lw64",  32'h104, 3'b010, 1, 32'h20, 0, 64'hFFFF_FFFF_8000_0000, 1'b0, 3);
    do_load(1'b1, "ill64", 32'h104, 3'b111, 0, 0, 0, 64'hFFFF_FFFF_8000_0000, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ama_riscv_load_align_unit.md
Name: ama_riscv_load_align_unit

Overview:
- Parametrised successor to the single-word load shift/mask stage. Takes a load request (byte address plus funct3) from the MEM stage and fetches one or two naturally aligned memory words. It shifts, masks and sign/zero-extends the addressed bytes into an XLEN result.
- Adds support for misaligned loads that cross a word boundary, using a two-beat fetch state machine. Also adds XLEN=64 (ld/lwu) and an explicit error response for illegal widths.

Parameters:
- XLEN, 32, data width in bits; legal values 32 or 64
- AW, 32, byte-address width
- OFF_W, $clog2(XLEN/8), byte-offset width within a word (derived, not overridable)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- req_valid  in  1  load request valid
- req_ready  out  1  unit can accept a request
- req_addr  in  AW  byte address of the load
- req_funct3  in  3  000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu
- mem_req  out  1  single-cycle read strobe to memory
- mem_addr  out  AW-OFF_W  word address of the read
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data, little-endian
- resp_valid  out  1  single-cycle result strobe
- resp_data  out  XLEN  extended load result
- resp_err  out  1  illegal funct3 for this XLEN; qualified by resp_valid

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state goes to IDLE.
  - req_ready=1; mem_req, resp_valid and resp_err are 0.
  - mem_addr and resp_data are 0.
  - rst asserted mid-operation aborts the load with no response; late mem_rvalid is ignored.
- Size in bytes is 2^funct3[1:0].
- Illegal funct3:
  - Any value 111.
  - For XLEN=32: 011 and 110.
  - On acceptance the unit skips memory and goes to RESP with resp_err=1. resp_data holds its previous value.
- Crossing condition: off + size > XLEN/8, where off = req_addr[OFF_W-1:0].
- Handshake: a request is accepted when req_valid && req_ready. req_ready=1 only in IDLE. Address, funct3 and off are latched on acceptance.
- Memory contract (decided):
  - Memory accepts every mem_req.
  - It returns exactly one mem_rvalid per mem_req, in order, no earlier than the cycle after the request.
- FSM:
  - IDLE: on accept, legal funct3 → REQ0; illegal → RESP.
  - REQ0: mem_req=1 and mem_addr = latched addr >> OFF_W, for exactly one cycle → WAIT0.
  - WAIT0: on mem_rvalid, capture beat0; crossing → REQ1, else → RESP.
  - REQ1: mem_req=1 and mem_addr = word addr + 1, wrapping modulo 2^(AW-OFF_W) → WAIT1.
  - WAIT1: on mem_rvalid, capture beat1 → RESP.
  - RESP: resp_valid=1 for exactly one cycle → IDLE. req_ready returns to 1 in the following cycle.
- Result formation:
  - Form {beat1, beat0}, with beat1=0 when not crossing.
  - Shift right by off*8 and keep the low size bytes.
  - Sign-extend from the top kept bit when funct3[2]=0; zero-extend when funct3[2]=1.
  - Word/double at size==XLEN/8 passes through unchanged.
- resp_data and resp_err are registered and hold between responses. This mirrors the hold-previous behaviour of the old stage when not enabled.
- Latency:
  - Aligned: accept at T, mem_req at T+1, rvalid at T+1+L, resp_valid at T+2+L.
  - Crossing: adds (1 + L2) cycles, where L2 is the second-beat memory latency.
  - Illegal: resp_valid at T+1.
- mem_rvalid while in IDLE, REQx or RESP is ignored.
- req_valid while req_ready=0 is not accepted and produces no side effect.

Test Plan:
- XLEN=32, lb addr 0x1001, mem word 0x12348678 → one mem_req, mem_addr 0x400; resp_data 0xFFFFFF86, resp_err 0. Repeat with lbu → 0x00000086.
- lw addr 0x1003, word 0x400=0xAABBCCDD, word 0x401=0x11223344 (L=1) → two mem_req (0x400 then 0x401); resp_data 0x223344AA.
- lh addr 0x0003, word0 0x80000000, word1 0x000000FF → crossing; resp_data 0xFFFFFF80. lhu → 0x0000FF80.
- XLEN=32, funct3 011 → no mem_req; resp_valid at T+1 with resp_err 1; resp_data unchanged from the previous response.
- rst pulsed in WAIT1, followed by a stray mem_rvalid → no resp_valid; req_ready=1 the cycle after rst. The next aligned lw of 0xDEADBEEF returns 0xDEADBEEF.
- XLEN=64, AW=32: ld addr 0xFFFFFFFC (off 4) → second mem_addr wraps to 0; result = {beat1[31:0], beat0[63:32]}. lwu off 4 of 0x80000000_00000000 → 0x00000000_80000000.
